// File: rtl/ext_intf_sender_p_pkg.sv
// rtl/ext_intf_sender_p_pkg.sv - link phases, FSM states and beat-count helper (package ext_intf_pkg)
package ext_intf_pkg;

    localparam logic [2:0] PH_CNTR = 3'b100;
    localparam logic [2:0] PH_ADDR = 3'b010;
    localparam logic [2:0] PH_WDAT = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CNTR  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDAT  = 3'd3,
        ST_RDAT  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    function automatic int nbeats(input int width);
        return 32 / width;
    endfunction

endpackage

// File: rtl/ext_intf_sender_p_if.sv
// rtl/ext_intf_sender_p_if.sv - SCx bus-slave and external link signal bundle for ext_intf_sender_p
interface ext_intf_sender_p_if #(
    parameter int LINK_DW = 16,
    parameter int RSP_DW  = 8
);
    logic                SCx_REQ;
    logic                SCx_WT;
    logic [3:0]          SCx_BE;
    logic [31:0]         SCx_ADDR;
    logic [31:0]         SCx_WDT;
    logic                SCx_nWAIT;
    logic                SCx_FAULT;
    logic                SCx_TimeOut;
    logic [31:0]         SCx_RDT;
    logic                Ext_TRANS_VALID;
    logic [2:0]          Ext_TRANS_PHASE;
    logic [LINK_DW-1:0]  Ext_TRANS_DATA;
    logic                Ext_TRANS_ACK;
    logic                Ext_RESP_VALID;
    logic                Ext_RESP_RESP;
    logic [RSP_DW-1:0]   Ext_RESP_DATA;
    logic                Ext_RESP_ACK;

    modport slave (
        input  SCx_REQ, SCx_WT, SCx_BE, SCx_ADDR, SCx_WDT,
        output SCx_nWAIT, SCx_FAULT, SCx_TimeOut, SCx_RDT,
        output Ext_TRANS_VALID, Ext_TRANS_PHASE, Ext_TRANS_DATA,
        input  Ext_TRANS_ACK,
        input  Ext_RESP_VALID, Ext_RESP_RESP, Ext_RESP_DATA,
        output Ext_RESP_ACK
    );

    modport master (
        output SCx_REQ, SCx_WT, SCx_BE, SCx_ADDR, SCx_WDT,
        input  SCx_nWAIT, SCx_FAULT, SCx_TimeOut, SCx_RDT,
        input  Ext_TRANS_VALID, Ext_TRANS_PHASE, Ext_TRANS_DATA,
        output Ext_TRANS_ACK,
        output Ext_RESP_VALID, Ext_RESP_RESP, Ext_RESP_DATA,
        input  Ext_RESP_ACK
    );
endinterface

// File: rtl/ext_intf_sender_p_fifo.sv
// rtl/ext_intf_sender_p_fifo.sv - single-clock FIFO (ext_sync_fifo) with registered pointers
module ext_sync_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(D);

    logic [W-1:0] r_mem [D];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_do_push;
    logic         w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/ext_intf_sender_p.sv
// rtl/ext_intf_sender_p.sv - SCx-to-link bridge; EXT_SENDER_TIMEOUT_EN adds read timeout and drain
module ext_intf_sender_p
    import ext_intf_pkg::*;
#(
    parameter int LINK_DW   = 16,
    parameter int RSP_DW    = 8,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4,
    parameter int TO_CYCLES = 1024
) (
    input logic                i_clk,
    input logic                i_rst,
    ext_intf_sender_p_if.slave bus
);
    localparam int NA  = nbeats(LINK_DW);
    localparam int NR  = nbeats(RSP_DW);
    localparam int TXW = 3 + LINK_DW;
    localparam int RXW = 1 + RSP_DW;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_bc;
    logic               r_wt;
    logic [3:0]         r_be;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdt;
    logic [31:0]        r_shadow;
    logic [31:0]        r_rdt;
    logic               r_err;
    logic               r_fault;

    logic               w_tx_push;
    logic [TXW-1:0]     w_tx_din;
    logic [TXW-1:0]     w_tx_dout;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic [RXW-1:0]     w_rx_dout;
    logic               w_rx_full;
    logic               w_rx_empty;

    logic               w_accept;
    logic               w_bc_clr;
    logic               w_bc_inc;
    logic               w_rd_done;
    logic               w_to_fire;
    logic [LINK_DW-1:0] w_addr_beat;
    logic [LINK_DW-1:0] w_wdt_beat;
    logic [31:0]        w_shadow_nxt;

`ifdef EXT_SENDER_TIMEOUT_EN
    logic [15:0]        r_to_cnt;
    logic [2:0]         r_rem;
    logic               r_timeout;
    assign bus.SCx_TimeOut = r_timeout;
`else
    logic               w_unused_to;
    assign w_unused_to     = (TO_CYCLES == 0);
    assign bus.SCx_TimeOut = 1'b0;
`endif

    ext_sync_fifo #(.W(TXW), .D(TX_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_tx_push),
        .i_data  (w_tx_din),
        .i_pop   (bus.Ext_TRANS_ACK),
        .o_data  (w_tx_dout),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    // Every landed response beat is consumed the next cycle; the FSM decides whether it counts.
    ext_sync_fifo #(.W(RXW), .D(RX_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (bus.Ext_RESP_VALID),
        .i_data  ({bus.Ext_RESP_RESP, bus.Ext_RESP_DATA}),
        .i_pop   (1'b1),
        .o_data  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign bus.SCx_nWAIT       = (r_state == ST_IDLE) & ~w_tx_full;
    assign bus.SCx_FAULT       = r_fault;
    assign bus.SCx_RDT         = r_rdt;
    assign bus.Ext_TRANS_VALID = ~w_tx_empty;
    assign bus.Ext_TRANS_PHASE = w_tx_dout[TXW-1 -: 3];
    assign bus.Ext_TRANS_DATA  = w_tx_dout[LINK_DW-1:0];
    assign bus.Ext_RESP_ACK    = ~w_rx_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tx_push    = 1'b0;
        w_tx_din     = '0;
        w_accept     = 1'b0;
        w_bc_clr     = 1'b0;
        w_bc_inc     = 1'b0;
        w_rd_done    = 1'b0;
        w_to_fire    = 1'b0;
        w_addr_beat  = LINK_DW'(r_addr >> (LINK_DW * int'(r_bc)));
        w_wdt_beat   = LINK_DW'(r_wdt >> (LINK_DW * int'(r_bc)));
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[int'(r_bc)*RSP_DW +: RSP_DW] = w_rx_dout[RSP_DW-1:0];
        case (r_state)
            ST_IDLE: if (bus.SCx_REQ && !w_tx_full) begin
                w_accept    = 1'b1;
                w_bc_clr    = 1'b1;
                w_state_nxt = ST_CNTR;
            end
            ST_CNTR: if (!w_tx_full) begin
                w_tx_push   = 1'b1;
                w_tx_din    = {PH_CNTR, LINK_DW'({r_wt, r_be})};
                w_bc_clr    = 1'b1;
                w_state_nxt = ST_ADDR;
            end
            ST_ADDR: if (!w_tx_full) begin
                w_tx_push = 1'b1;
                w_tx_din  = {PH_ADDR, w_addr_beat};
                if (r_bc == 3'(NA-1)) begin
                    w_bc_clr    = 1'b1;
                    w_state_nxt = r_wt ? ST_WDAT : ST_RDAT;
                end else begin
                    w_bc_inc = 1'b1;
                end
            end
            ST_WDAT: if (!w_tx_full) begin
                w_tx_push = 1'b1;
                w_tx_din  = {PH_WDAT, w_wdt_beat};
                if (r_bc == 3'(NA-1)) begin
                    w_bc_clr    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_bc_inc = 1'b1;
                end
            end
            ST_RDAT: begin
                if (!w_rx_empty) begin
                    if (r_bc == 3'(NR-1)) begin
                        w_rd_done   = 1'b1;
                        w_bc_clr    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bc_inc = 1'b1;
                    end
                end
`ifdef EXT_SENDER_TIMEOUT_EN
                else if (r_to_cnt == 16'(TO_CYCLES-1)) begin
                    w_to_fire   = 1'b1;
                    w_bc_clr    = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
`endif
            end
`ifdef EXT_SENDER_TIMEOUT_EN
            ST_DRAIN: if (!w_rx_empty) begin
                if (r_bc == r_rem - 3'd1) begin
                    w_bc_clr    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_bc_inc = 1'b1;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bc     <= '0;
            r_wt     <= 1'b0;
            r_be     <= '0;
            r_addr   <= '0;
            r_wdt    <= '0;
            r_shadow <= '0;
            r_rdt    <= '0;
            r_err    <= 1'b0;
            r_fault  <= 1'b0;
`ifdef EXT_SENDER_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_rem     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_fault <= 1'b0;
            if (w_accept) begin
                r_wt   <= bus.SCx_WT;
                r_be   <= bus.SCx_BE;
                r_addr <= bus.SCx_ADDR;
                r_wdt  <= bus.SCx_WDT;
                r_err  <= 1'b0;
            end
            if (w_bc_clr)      r_bc <= '0;
            else if (w_bc_inc) r_bc <= r_bc + 3'd1;
            if (r_state == ST_RDAT && !w_rx_empty) begin
                r_shadow <= w_shadow_nxt;
                r_err    <= r_err | w_rx_dout[RXW-1];
            end
            // Fault lands in the first IDLE cycle, alongside the new read word.
            if (w_rd_done) begin
                r_rdt   <= w_shadow_nxt;
                r_fault <= r_err | w_rx_dout[RXW-1];
            end
`ifdef EXT_SENDER_TIMEOUT_EN
            r_timeout <= 1'b0;
            if (r_state == ST_RDAT && w_rx_empty) r_to_cnt <= r_to_cnt + 16'd1;
            else                                  r_to_cnt <= '0;
            if (w_to_fire) begin
                r_timeout <= 1'b1;
                r_fault   <= 1'b1;
                r_rem     <= 3'(NR) - r_bc;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ext_intf_sender_p.sv
// tb/tb_ext_intf_sender_p.sv - directed plus randomized self-checking bench for ext_intf_sender_p
module tb_ext_intf_sender_p;
    localparam int LINK_DW   = 16;
    localparam int RSP_DW    = 8;
    localparam int TO_CYCLES = 16;
    localparam int NA        = 32 / LINK_DW;
    localparam int NR        = 32 / RSP_DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_fault = 0;
    int   n_to    = 0;
    logic ack_fix  = 1'b1;
    logic ack_rand = 1'b0;
    logic rnd_bit  = 1'b1;
    logic [LINK_DW+2:0] mon_q[$];
    logic [LINK_DW+2:0] exp_q[$];

    ext_intf_sender_p_if #(.LINK_DW(LINK_DW), .RSP_DW(RSP_DW)) bus();

    ext_intf_sender_p #(
        .LINK_DW(LINK_DW), .RSP_DW(RSP_DW), .TX_DEPTH(4), .RX_DEPTH(4), .TO_CYCLES(TO_CYCLES)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.Ext_TRANS_ACK = ack_rand ? rnd_bit : ack_fix;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.Ext_TRANS_VALID && bus.Ext_TRANS_ACK)
                mon_q.push_back({bus.Ext_TRANS_PHASE, bus.Ext_TRANS_DATA});
            if (bus.SCx_FAULT)   n_fault++;
            if (bus.SCx_TimeOut) n_to++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected link stream: control word, then address and write data LSB-first.
    function automatic void build_exp(logic wt, logic [3:0] be, logic [31:0] a, logic [31:0] d);
        exp_q.delete();
        exp_q.push_back({3'b100, LINK_DW'({wt, be})});
        for (int i = 0; i < NA; i++) exp_q.push_back({3'b010, LINK_DW'(a >> (LINK_DW * i))});
        if (wt)
            for (int i = 0; i < NW(); i++) exp_q.push_back({3'b001, LINK_DW'(d >> (LINK_DW * i))});
    endfunction

    function automatic int NW();
        return 32 / LINK_DW;
    endfunction

    task automatic wait_beats(input string tag, input int n);
        int g = 0;
        while (mon_q.size() < n && g < 300) begin tick(); g++; end
        check({tag, " beat wait"}, 64'(g < 300), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (!bus.SCx_nWAIT && g < 300) begin tick(); g++; end
        check({tag, " idle wait"}, 64'(g < 300), 64'd1);
    endtask

    task automatic send_beat(input string tag, input logic [RSP_DW-1:0] dt, input logic er);
        int g = 0;
        bus.Ext_RESP_VALID = 1'b1;
        bus.Ext_RESP_DATA  = dt;
        bus.Ext_RESP_RESP  = er;
        while (!bus.Ext_RESP_ACK && g < 50) begin tick(); g++; end
        check({tag, " resp ack"}, 64'(g < 50), 64'd1);
        tick();
        bus.Ext_RESP_VALID = 1'b0;
    endtask

    task automatic issue(input logic wt, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        bus.SCx_REQ  = 1'b1;
        bus.SCx_WT   = wt;
        bus.SCx_BE   = be;
        bus.SCx_ADDR = a;
        bus.SCx_WDT  = d;
        tick();
        bus.SCx_REQ  = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic wt, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rw,
                           input logic [3:0] re, input bit chk_lat, input int hold);
        int base;
        int f0;
        build_exp(wt, be, a, d);
        wait_idle({tag, " pre"});
        base = mon_q.size();
        f0   = n_fault;
        issue(wt, be, a, d);
        if (chk_lat) begin
            for (int c = 1; c <= 6; c++) begin
                check($sformatf("%s nWAIT cycle%0d", tag, c), 64'(bus.SCx_nWAIT), 64'(c == 6));
                if (c < 6) tick();
            end
        end
        if (hold > 0) begin
            repeat (hold) tick();
            check({tag, " stalled nWAIT"}, 64'(bus.SCx_nWAIT), 64'd0);
            check({tag, " no beat while ACK=0"}, 64'(mon_q.size() - base), 64'd0);
            check({tag, " VALID held"}, 64'(bus.Ext_TRANS_VALID), 64'd1);
            ack_fix = 1'b1;
        end
        if (!wt) begin
            wait_beats(tag, base + 1 + NA);
            for (int i = 0; i < NR; i++) begin
                send_beat(tag, RSP_DW'(rw >> (RSP_DW * i)), re[i]);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        wait_idle(tag);
        wait_beats(tag, base + exp_q.size());
        tick();
        tick();
        check({tag, " beat count"}, 64'(mon_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s beat%0d", tag, i),
                  (base + i < mon_q.size()) ? 64'(mon_q[base + i]) : 64'hDEAD_DEAD, 64'(exp_q[i]));
        if (!wt) check({tag, " RDT"}, 64'(bus.SCx_RDT), 64'(rw));
        check({tag, " fault pulses"}, 64'(n_fault - f0), 64'(wt ? 1'b0 : (|re)));
    endtask

    initial begin
        logic [31:0] rdt_prev;
        int f0;
        int to0;
        int base;
        int g;
        bus.SCx_REQ = 1'b0; bus.SCx_WT = 1'b0; bus.SCx_BE = '0;
        bus.SCx_ADDR = '0;  bus.SCx_WDT = '0;
        bus.Ext_RESP_VALID = 1'b0; bus.Ext_RESP_RESP = 1'b0; bus.Ext_RESP_DATA = '0;
        tick();
        tick();
        check("reset nWAIT", 64'(bus.SCx_nWAIT), 64'd1);
        check("reset FAULT", 64'(bus.SCx_FAULT), 64'd0);
        check("reset TimeOut", 64'(bus.SCx_TimeOut), 64'd0);
        check("reset RDT", 64'(bus.SCx_RDT), 64'd0);
        check("reset TRANS_VALID", 64'(bus.Ext_TRANS_VALID), 64'd0);
        check("reset RESP_ACK", 64'(bus.Ext_RESP_ACK), 64'd1);
        rst = 1'b0;
        tick();

        run_txn("t1 write", 1'b1, 4'hF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0, 4'h0, 1'b1, 0);
        run_txn("t2 read", 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h1122_3344, 4'b0000, 1'b0, 0);
        run_txn("t3 read err", 1'b0, 4'h3, 32'h0000_0200, 32'h0, 32'hA5B6_C7D8, 4'b0100, 1'b0, 0);

        ack_fix = 1'b0;
        run_txn("t4 backpressure", 1'b1, 4'hC, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0, 4'h0, 1'b0, 20);

        rdt_prev = bus.SCx_RDT;
        f0 = n_fault;
        send_beat("unsolicited", 8'h77, 1'b1);
        repeat (4) tick();
        check("unsolicited no fault", 64'(n_fault - f0), 64'd0);
        check("unsolicited RDT kept", 64'(bus.SCx_RDT), 64'(rdt_prev));
        run_txn("after unsolicited", 1'b0, 4'h1, 32'h0000_0300, 32'h0, 32'h0F1E_2D3C, 4'h0, 1'b0, 0);

        ack_rand = 1'b1;
        for (int n = 0; n < 24; n++) begin
            logic [3:0] re;
            re = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            run_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    $urandom, $urandom, $urandom, re, 1'b0, 0);
        end
        ack_rand = 1'b0;
        ack_fix  = 1'b1;

`ifdef EXT_SENDER_TIMEOUT_EN
        rdt_prev = bus.SCx_RDT;
        to0 = n_to;
        wait_idle("t5 pre");
        base = mon_q.size();
        issue(1'b0, 4'hF, 32'h0000_0400, 32'h0);
        wait_beats("t5", base + 1 + NA);
        send_beat("t5", 8'h5A, 1'b0);
        g = 0;
        while (!bus.SCx_TimeOut && g < 100) begin tick(); g++; end
        check("t5 timeout seen", 64'(g < 100), 64'd1);
        check("t5 timeout latency in range", 64'(g >= 15 && g <= 19), 64'd1);
        check("t5 FAULT with TimeOut", 64'(bus.SCx_FAULT), 64'd1);
        check("t5 RDT unchanged", 64'(bus.SCx_RDT), 64'(rdt_prev));
        check("t5 nWAIT low in drain", 64'(bus.SCx_nWAIT), 64'd0);
        tick();
        check("t5 TimeOut one cycle", 64'(bus.SCx_TimeOut), 64'd0);
        for (int i = 0; i < 3; i++) send_beat("t5 late", 8'(8'hE0 + i), 1'b0);
        wait_idle("t5 drain");
        tick();
        check("t5 single timeout pulse", 64'(n_to - to0), 64'd1);
        check("t5 RDT after drain", 64'(bus.SCx_RDT), 64'(rdt_prev));
        run_txn("t5 next read", 1'b0, 4'hF, 32'h0000_0500, 32'h0, 32'h6677_8899, 4'h0, 1'b0, 0);
`else
        check("no TimeOut without feature", 64'(n_to), 64'd0);
`endif

        wait_idle("t6 pre");
        issue(1'b1, 4'hF, 32'h0000_0600, 32'h1357_9BDF);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("t6 TRANS_VALID in reset", 64'(bus.Ext_TRANS_VALID), 64'd0);
        check("t6 nWAIT in reset", 64'(bus.SCx_nWAIT), 64'd1);
        check("t6 RDT in reset", 64'(bus.SCx_RDT), 64'd0);
        check("t6 FAULT in reset", 64'(bus.SCx_FAULT), 64'd0);
        check("t6 RESP_ACK in reset", 64'(bus.Ext_RESP_ACK), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        base = mon_q.size();
        repeat (6) tick();
        check("t6 no beats after reset", 64'(mon_q.size() - base), 64'd0);
        run_txn("t6 clean write", 1'b1, 4'h5, 32'h2468_ACE0, 32'hFEDC_BA98, 32'h0, 4'h0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
